// File: rtl/fpalu_pkg.sv
// Shared definitions for the FPALU request/response front end.
// Opcodes, flag bit positions, responder states and the latency record.
package fpalu_pkg;

    localparam int CNT_W = 8;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_MUL   = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_SQRT  = 4'd4;
    localparam logic [3:0] OP_ABS   = 4'd5;
    localparam logic [3:0] OP_NEG   = 4'd6;
    localparam logic [3:0] OP_CEQ   = 4'd7;
    localparam logic [3:0] OP_CLT   = 4'd8;
    localparam logic [3:0] OP_CLE   = 4'd9;
    localparam logic [3:0] OP_CVTSW = 4'd10;
    localparam logic [3:0] OP_CVTWS = 4'd11;
    localparam logic [3:0] OP_LAST  = 4'd11;

    localparam int FLG_ZERO = 0;
    localparam int FLG_OVF  = 1;
    localparam int FLG_UNF  = 2;
    localparam int FLG_CMP  = 3;
    localparam int FLG_NAN  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // cnt holds latency minus one, ready to load into the wait counter
    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic             legal;
    } lat_t;

endpackage

// File: rtl/fpalu_lat_lut.sv
// Opcode to pipeline-latency lookup for the FPALU responder.
// Pure combinational; undefined opcodes come back with legal=0.
module fpalu_lat_lut
    import fpalu_pkg::*;
#(
    parameter int LAT_ADD  = 7,
    parameter int LAT_MUL  = 5,
    parameter int LAT_DIV  = 6,
    parameter int LAT_SQRT = 16,
    parameter int LAT_MISC = 1
) (
    input  logic [3:0] op,
    output lat_t       lat
);

    localparam int LAT_MAX = 1 << CNT_W;

    generate
        if (LAT_ADD < 1 || LAT_MUL < 1 || LAT_DIV < 1 ||
            LAT_SQRT < 1 || LAT_MISC < 1) begin : g_lat_low
            $error("fpalu_lat_lut: every latency must be >= 1");
        end
        if (LAT_ADD > LAT_MAX || LAT_MUL > LAT_MAX ||
            LAT_DIV > LAT_MAX || LAT_SQRT > LAT_MAX ||
            LAT_MISC > LAT_MAX) begin : g_lat_high
            $error("fpalu_lat_lut: latency exceeds counter range");
        end
    endgenerate

    localparam logic [CNT_W-1:0] C_ADD  = CNT_W'(LAT_ADD - 1);
    localparam logic [CNT_W-1:0] C_MUL  = CNT_W'(LAT_MUL - 1);
    localparam logic [CNT_W-1:0] C_DIV  = CNT_W'(LAT_DIV - 1);
    localparam logic [CNT_W-1:0] C_SQRT = CNT_W'(LAT_SQRT - 1);
    localparam logic [CNT_W-1:0] C_MISC = CNT_W'(LAT_MISC - 1);

    always_comb begin
        lat = '0;
        unique case (1'b1)
            (op == OP_ADD) || (op == OP_SUB): begin
                lat.cnt   = C_ADD;
                lat.legal = 1'b1;
            end
            (op == OP_MUL): begin
                lat.cnt   = C_MUL;
                lat.legal = 1'b1;
            end
            (op == OP_DIV): begin
                lat.cnt   = C_DIV;
                lat.legal = 1'b1;
            end
            (op == OP_SQRT): begin
                lat.cnt   = C_SQRT;
                lat.legal = 1'b1;
            end
            (op >= OP_ABS) && (op <= OP_LAST): begin
                lat.cnt   = C_MISC;
                lat.legal = 1'b1;
            end
            default: lat = '0;
        endcase
    end

endmodule

// File: rtl/fpalu_req_responder.sv
// Valid/ready front end for one FPALU: holds operands for the op latency,
// captures result and flags, and presents them under a response handshake.
module fpalu_req_responder
    import fpalu_pkg::*;
#(
    parameter int LAT_ADD  = 7,
    parameter int LAT_MUL  = 5,
    parameter int LAT_DIV  = 6,
    parameter int LAT_SQRT = 16,
    parameter int LAT_MISC = 1
) (
    input  logic        iclock,
    input  logic        ireset_n,
    input  logic        ivalid,
    output logic        oready,
    input  logic [31:0] idataa,
    input  logic [31:0] idatab,
    input  logic [3:0]  icontrol,
    output logic [31:0] ofpa_dataa,
    output logic [31:0] ofpa_datab,
    output logic [3:0]  ofpa_control,
    input  logic [31:0] ifpa_result,
    input  logic [4:0]  ifpa_flags,
    output logic        ovalid,
    input  logic        iready,
    output logic [31:0] oresult,
    output logic [4:0]  oflags,
    output logic        oillegal
);

    state_t           state, state_nx;
    logic             armed;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [31:0]      fa_nx, fb_nx, res_nx;
    logic [3:0]       fc_nx;
    logic [4:0]       flg_nx;
    logic             ill_nx;
    lat_t             lat;

    fpalu_lat_lut #(
        .LAT_ADD  (LAT_ADD),
        .LAT_MUL  (LAT_MUL),
        .LAT_DIV  (LAT_DIV),
        .LAT_SQRT (LAT_SQRT),
        .LAT_MISC (LAT_MISC)
    ) u_lut (
        .op  (icontrol),
        .lat (lat)
    );

    // armed keeps oready low until the first edge after reset release
    assign oready = armed && (state == IDLE);
    assign ovalid = (state == RESP);

    always_ff @(posedge iclock or negedge ireset_n) begin
        if (!ireset_n) begin
            state        <= IDLE;
            armed        <= 1'b0;
            cnt          <= '0;
            ofpa_dataa   <= '0;
            ofpa_datab   <= '0;
            ofpa_control <= '0;
            oresult      <= '0;
            oflags       <= '0;
            oillegal     <= 1'b0;
        end else begin
            state        <= state_nx;
            armed        <= 1'b1;
            cnt          <= cnt_nx;
            ofpa_dataa   <= fa_nx;
            ofpa_datab   <= fb_nx;
            ofpa_control <= fc_nx;
            oresult      <= res_nx;
            oflags       <= flg_nx;
            oillegal     <= ill_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        fa_nx    = ofpa_dataa;
        fb_nx    = ofpa_datab;
        fc_nx    = ofpa_control;
        res_nx   = oresult;
        flg_nx   = oflags;
        ill_nx   = oillegal;
        unique case (state)
            IDLE: begin
                if (ivalid && oready) begin
                    if (lat.legal) begin
                        fa_nx    = idataa;
                        fb_nx    = idatab;
                        fc_nx    = icontrol;
                        cnt_nx   = lat.cnt;
                        state_nx = WAIT;
                    end else begin
                        ill_nx   = 1'b1;
                        res_nx   = '0;
                        flg_nx   = '0;
                        state_nx = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else begin
                    res_nx   = ifpa_result;
                    flg_nx   = ifpa_flags;
                    ill_nx   = 1'b0;
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (iready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: doc/fpalu_req_responder.md
Name: fpalu_req_responder

Overview:
- Request/response front end for the FPALU core; it is the responder side of the operand/control interface that the board top level drives directly today.
- Accepts one operation per valid/ready handshake and drives the FPALU's idataa, idatab and icontrol inputs, holding them stable.
- Waits the op-specific pipeline latency, then captures oresult plus the five flags and presents them under a valid/ready response handshake.
- Sits between any requester (board top, CPU FP coprocessor port) and one FPALU instance.

Parameters:
- LAT_ADD, 7, cycles from accept to capture for add/sub
- LAT_MUL, 5, cycles for mul
- LAT_DIV, 6, cycles for div
- LAT_SQRT, 16, cycles for sqrt
- LAT_MISC, 1, cycles for abs/neg/compares/conversions

Ports:
- iclock  in  1  single clock, posedge
- ireset_n  in  1  asynchronous active-low reset
- ivalid  in  1  request valid
- oready  out  1  request accepted when ivalid&&oready at posedge
- idataa  in  32  operand A (IEEE-754 single)
- idatab  in  32  operand B
- icontrol  in  4  opcode
- ofpa_dataa  out  32  to FPALU idataa
- ofpa_datab  out  32  to FPALU idatab
- ofpa_control  out  4  to FPALU icontrol
- ifpa_result  in  32  from FPALU oresult
- ifpa_flags  in  5  from FPALU {onan, oCompResult, ounderflow, ooverflow, ozero}
- ovalid  out  1  response valid
- iready  in  1  response consumed when ovalid&&iready at posedge
- oresult  out  32  captured result
- oflags  out  5  captured flags, same bit order as ifpa_flags
- oillegal  out  1  opcode outside the defined set

Behaviour:
- Reset (async, ireset_n=0):
  - state=IDLE
  - oready=0 while in reset, 1 after the first posedge out of reset
  - ovalid=0, oresult=0, oflags=0, oillegal=0
  - ofpa_*=0, counter=0
- States:
  - IDLE, oready=1: on accept of a defined opcode, register operands into ofpa_*, load counter=LAT(op)-1, go to WAIT. On accept of an undefined opcode, leave ofpa_* unchanged, set oillegal=1, oresult=0, oflags=0, go to RESP.
  - WAIT, oready=0: ofpa_* held constant. If counter!=0, decrement. If counter==0, capture ifpa_result/ifpa_flags into oresult/oflags, oillegal=0, go to RESP.
  - RESP, ovalid=1, oready=0: outputs held stable until ovalid&&iready, then ovalid=0, go to IDLE.
- Latency: ovalid rises exactly LAT(op) posedges after the accepting posedge; illegal opcodes take 1. Back-to-back throughput is LAT+2 cycles per op when iready is held high. No overlap and no bypass: oready is a pure state decode with no combinational path from iready.
- Opcode map (4 bits):
  - 0 add, 1 sub: LAT_ADD
  - 2 mul: LAT_MUL
  - 3 div: LAT_DIV
  - 4 sqrt: LAT_SQRT
  - 5 abs, 6 neg, 7 ceq, 8 clt, 9 cle, 10 cvt.s.w, 11 cvt.w.s: LAT_MISC
  - 12-15: illegal
- ivalid while oready=0 is ignored, not queued; the requester must hold ivalid.
- iready asserted with ovalid=0 has no effect.
- Reset asserted mid-WAIT or mid-RESP: operation dropped, no response issued.
- Parameter legality: every LAT_* must be >=1; elaboration fails otherwise.

Decomposition:
- Package fpalu_pkg holds:
  - opcode constants OP_ADD…OP_CVTWS, OP_LAST=11
  - flag bit indices FLG_ZERO=0, FLG_OVF=1, FLG_UNF=2, FLG_CMP=3, FLG_NAN=4
  - state encoding (IDLE, WAIT, RESP)
- One natural sub-module, fpalu_lat_lut: combinational opcode→{latency, legal} lookup, parameterised with the LAT_* values.

Test Plan:
- add 3F800000+40000000 (1.0+2.0), iready=1 -> ovalid exactly 7 cycles after accept; oresult=40400000, oflags=0, oillegal=0; ovalid for 1 cycle.
- mul 40400000*40000000 -> oresult=40C00000 at accept+5. iready held 0 for 10 cycles -> oresult/oflags stable, oready=0 throughout; ovalid drops the cycle after iready=1.
- sub 3F800000-3F800000 -> oresult=00000000, oflags[FLG_ZERO]=1. clt 3F800000,40000000 -> oflags[FLG_CMP]=1 at accept+1.
- icontrol=4'hE -> oillegal=1, oresult=0 one cycle after accept; ofpa_* unchanged from the previous op.
- sqrt accepted; ivalid pulsed during WAIT -> not accepted. ireset_n low at accept+8 -> all outputs 0 immediately, no ovalid afterward; next request behaves normally.
- Four back-to-back add ops, iready=1 -> accepts spaced 9 cycles apart, results in order.
